// File: rtl/arith_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: stage count and
// the width/slice legality test used at elaboration time.
package arith_pkg;

    // Number of lookahead groups (one per pipeline stage) for a given width.
    function automatic int cla_stages(input int width, input int slice);
        return (slice > 0) ? (width / slice) : 1;
    endfunction

    // A width is legal only when it splits into whole, non-empty slices.
    function automatic bit cla_width_ok(input int width, input int slice);
        return (slice > 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// One combinational carry-lookahead group. Every internal carry is built as
// a flat sum of products of generate/propagate terms and the group carry-in,
// so no carry ripples bit-to-bit through the group.
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Carry into bit i+1 = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c_in.
    always_comb begin
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b0;
        c   = '0;
        c[0] = c_in;
        for (int i = 0; i < SLICE; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            acc = acc | (pp & c_in);
            c[i+1] = acc;
        end
    end

    assign s        = p ^ c[SLICE-1:0];
    assign c_out    = c[SLICE];
    assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one SLICE
// group using the carry registered by the previous stage and carries the
// not-yet-summed operand bits forward. Per-stage valid bits with bubble
// collapse give full throughput and lossless backpressure.
module cla_pipe_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = cla_stages(WIDTH, SLICE);

    if (!cla_width_ok(WIDTH, SLICE)) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH (%0d) must be a positive multiple of SLICE (%0d)",
               WIDTH, SLICE);
    end

    logic [WIDTH-1:0]  b_eff;
    logic              c_first;
    logic [STAGES:0]   adv;   // adv[s]: stage s may load this cycle
    logic [STAGES-1:0] vld;

    // Subtraction is a + ~b + 1; the external carry-in is ignored then.
    assign b_eff       = sub ? ~b : b;
    assign c_first     = sub | cin;
    assign adv[STAGES] = out_ready;
    assign in_ready    = adv[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int REM_W  = WIDTH - SLICE * s;   // operand bits still to sum
        localparam int DONE_W = SLICE * (s + 1);     // sum bits finished here

        logic [REM_W-1:0]  rem_a;
        logic [REM_W-1:0]  rem_b;
        logic [DONE_W-1:0] sum_d;
        logic [DONE_W-1:0] sum_q;
        logic              vld_q;
        logic              c_q;
        logic              up_vld;
        logic              sl_cin;
        logic              load;
        logic [SLICE-1:0]  sl_s;
        logic              sl_cout;
        logic              sl_cmsb;

        if (s == 0) begin : g_src
            assign rem_a  = a;
            assign rem_b  = b_eff;
            assign sl_cin = c_first;
            assign up_vld = in_valid;
            assign sum_d  = sl_s;
        end else begin : g_src
            assign rem_a  = g_stage[s-1].g_hold.a_q;
            assign rem_b  = g_stage[s-1].g_hold.b_q;
            assign sl_cin = g_stage[s-1].c_q;
            assign up_vld = vld[s-1];
            assign sum_d  = {sl_s, g_stage[s-1].sum_q};
        end

        cla_slice #(.SLICE(SLICE)) u_slice (
            .a        (rem_a[SLICE-1:0]),
            .b        (rem_b[SLICE-1:0]),
            .c_in     (sl_cin),
            .s        (sl_s),
            .c_out    (sl_cout),
            .c_msb_in (sl_cmsb)
        );

        assign vld[s] = vld_q;
        assign adv[s] = !vld_q || adv[s+1];
        assign load   = adv[s] && up_vld;

        // Valid follows the upstream stage whenever this stage may advance.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else if (adv[s]) begin
                vld_q <= up_vld;
            end
        end

        // Finished sum bits and group carry load only with a real operation.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (load) begin
                sum_q <= sum_d;
                c_q   <= sl_cout;
            end
        end

        if (s < STAGES - 1) begin : g_hold
            logic [REM_W-SLICE-1:0] a_q;
            logic [REM_W-SLICE-1:0] b_q;
            logic                   unused_cmsb;

            // Only the final group's top-bit carry matters for overflow.
            assign unused_cmsb = sl_cmsb;

            // Carry the unprocessed upper operand bits to the next group.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= rem_a[REM_W-1:SLICE];
                    b_q <= rem_b[REM_W-1:SLICE];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (load) begin
                    ovf_q <= sl_cmsb ^ sl_cout;
                end
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
